lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit sitting directly downstream of the ALU: takes the ALU result as the effective
//  address, performs a byte/half/word access on a single-port data memory, and returns the
//  aligned, extended load data to the writeback mux.
//  Stalls the core via core_stall_o until the memory access completes.
//  Detects misaligned accesses and memory timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in REQ waiting for mem_ready_i; 0 = wait forever
// PORTS
//  clk_i          in   1   core clock, all state updates on rising edge
//  rst_i          in   1   synchronous, active-high reset
//  core_req_i     in   1   current instruction is a load/store
//  core_we_i      in   1   1 = store, 0 = load
//  core_size_i    in   3   access size code (LDST_*), RISC-V funct3 encoding
//  core_addr_i    in   32  effective address (ALU result_o)
//  core_wd_i      in   32  store data (rs2)
//  core_rd_o      out  32  aligned, extended load data
//  core_stall_o   out  1   1 = hold PC/pipeline, access not yet complete
//  lsu_err_o      out  1   1-cycle pulse in DONE: misaligned, illegal size, or timeout
//  mem_req_o      out  1   memory request
//  mem_we_o       out  1   memory write enable
//  mem_be_o       out  4   byte-lane enables
//  mem_addr_o     out  32  word address {addr[31:2],2'b00}
//  mem_wd_o       out  32  lane-replicated write data
//  mem_rd_i       in   32  memory read word, valid when mem_ready_i=1
//  mem_ready_i    in   1   memory accepts write / returns read this cycle
// BEHAVIOUR
//  Reset: state=IDLE; core_rd_o, mem_* = 0; lsu_err_o = 0; timeout counter = 0.
//  FSM IDLE -> REQ -> DONE -> IDLE.
//  - IDLE
//    - core_stall_o = core_req_i (combinational).
//    - On core_req_i=1: latch we, size, addr, wd.
//    - Legal request -> REQ. Misaligned or illegal size -> DONE with error flag set, no memory access.
//  - REQ
//    - mem_req_o=1; mem_we_o/be/addr/wd driven from latched registers, stable for the whole state.
//    - core_stall_o=1.
//    - On mem_ready_i=1: a load captures the extracted word into core_rd_o; -> DONE.
//    - Timeout counter increments each REQ cycle. At TIMEOUT_CYCLES (if nonzero) -> DONE with error;
//      core_rd_o unchanged.
//  - DONE
//    - core_stall_o=0 and mem_req_o=0 for exactly 1 cycle; lsu_err_o = latched error flag.
//    - -> IDLE. A request seen in the following IDLE cycle is a new instruction.
//  Latency: minimum 2 stall cycles; a zero-wait memory gives stall high in IDLE and REQ, low in DONE.
//  Misalignment:
//  - H/HU with addr[0]=1.
//  - W with addr[1:0]!=0.
//  - Size codes 3, 6, 7 are illegal.
//  Store lanes: off = addr[1:0].
//  - B: be = 4'b0001<<off, wd = {4{wd[7:0]}}.
//  - H: be = 4'b0011<<off, wd = {2{wd[15:0]}}.
//  - W: be = 4'b1111.
//  Load extract: shifted = mem_rd_i >> (8*off).
//  - B/H: sign-extend bit 7/15.
//  - BU/HU: zero-extend.
//  - W: pass the word through.
//  Load data hold: core_rd_o holds its value until the next successful load; stores and errors
//  never modify it.
//  Reset mid-access: the next edge forces IDLE; mem_req_o drops and the access is abandoned.
//  mem_ready_i outside REQ: ignored.
// STRUCTURE
//  Shared package riscv_pkg:
//  - LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5.
//  - lsu_state_t enum {LSU_IDLE, LSU_REQ, LSU_DONE}.
//  Sub-module lsu_data_align (combinational):
//  - size + offset -> be, store-data replication, load extraction/extension, misalign flag.
//  - Instantiated once; lsu_ctrl keeps the FSM, latches and timeout counter.
// TESTING
//  1. Store B:
//     - Stimulus: addr=0x103, wd=0xAABBCCDD, ready=1.
//     - Response: mem_be_o=1000, mem_addr_o=0x100, mem_wd_o=0xDDDDDDDD; stall 2 cycles, then 0.
//  2. Load H/HU at offset 2:
//     - Stimulus: addr=0x202, mem_rd_i=0x8001_1234.
//     - Response: H -> core_rd_o=0xFFFF8001; HU -> 0x00008001.
//  3. Misaligned load W:
//     - Stimulus: addr=0x301.
//     - Response: mem_req_o never 1; lsu_err_o pulse in cycle 2; core_rd_o unchanged.
//  4. Wait states:
//     - Stimulus: load W, mem_ready_i=0 for 3 cycles, then 1 with rd=0xCAFEBABE.
//     - Response: stall high for 5 cycles; core_rd_o=0xCAFEBABE.
//  5. Timeout:
//     - Stimulus: TIMEOUT_CYCLES=4, ready held 0.
//     - Response: 4 REQ cycles, then DONE with lsu_err_o=1, mem_req_o=0.
//  6. Reset mid-REQ:
//     - Stimulus: rst_i=1 during REQ.
//     - Response: next edge mem_req_o=0, core_rd_o=0, state IDLE; back-to-back requests afterwards work.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access size codes (RISC-V funct3 encoding)
// and the LSU control FSM state type.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane alignment for the LSU.
//  i_size      access size code (LDST_*)
//  i_off       byte offset within the word (addr[1:0])
//  i_wd        raw store data (rs2)
//  i_rd        raw memory read word
//  o_be        byte-lane enables
//  o_wd        lane-replicated store data
//  o_rd        shifted, sign/zero-extended load data
//  o_misalign  misaligned access or illegal size code
module lsu_data_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_rd,
  output logic [3:0]  o_be,
  output logic [31:0] o_wd,
  output logic [31:0] o_rd,
  output logic        o_misalign
);

  logic [31:0] w_shift;

  // Addressed byte/half moved down to bit 0.
  assign w_shift = i_rd >> {i_off, 3'b000};

  always_comb begin
    o_be       = 4'b0000;
    o_wd       = i_wd;
    o_rd       = w_shift;
    o_misalign = 1'b0;
    case (i_size)
      LDST_B: begin
        o_be = 4'b0001 << i_off;
        o_wd = {4{i_wd[7:0]}};
        o_rd = {{24{w_shift[7]}}, w_shift[7:0]};
      end
      LDST_BU: begin
        o_be = 4'b0001 << i_off;
        o_wd = {4{i_wd[7:0]}};
        o_rd = {24'd0, w_shift[7:0]};
      end
      LDST_H: begin
        o_be       = 4'b0011 << i_off;
        o_wd       = {2{i_wd[15:0]}};
        o_rd       = {{16{w_shift[15]}}, w_shift[15:0]};
        o_misalign = i_off[0];
      end
      LDST_HU: begin
        o_be       = 4'b0011 << i_off;
        o_wd       = {2{i_wd[15:0]}};
        o_rd       = {16'd0, w_shift[15:0]};
        o_misalign = i_off[0];
      end
      LDST_W: begin
        o_be       = 4'b1111;
        o_misalign = |i_off;
      end
      // Codes 3, 6, 7 are not valid load/store sizes.
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: drives a single-port data memory from the ALU effective
// address, stalls the core until the access completes, and returns aligned,
// extended load data. Flags misaligned/illegal accesses and memory timeouts.
//  clk_i, rst_i           clock, synchronous active-high reset
//  core_req/we/size/addr/wd_i  access request from the core
//  core_rd_o              load data (held until the next successful load)
//  core_stall_o           hold pipeline while the access is in flight
//  lsu_err_o              one-cycle error pulse in DONE
//  mem_req/we/be/addr/wd_o, mem_rd_i, mem_ready_i  data memory interface
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);

  lsu_state_t  r_state, w_next;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic        r_err;
  logic [31:0] r_tcnt;
  logic [31:0] r_rd;

  logic [2:0]  w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_rd;
  logic        w_misalign;
  logic        w_timeout;

  // In IDLE the aligner checks the incoming request; afterwards it works
  // from the latched copy so memory outputs stay stable through REQ.
  assign w_size = (r_state == LSU_IDLE) ? core_size_i      : r_size;
  assign w_off  = (r_state == LSU_IDLE) ? core_addr_i[1:0] : r_addr[1:0];

  lsu_data_align u_align (
    .i_size     (w_size),
    .i_off      (w_off),
    .i_wd       (r_wd),
    .i_rd       (mem_rd_i),
    .o_be       (w_be),
    .o_wd       (w_wd),
    .o_rd       (w_rd),
    .o_misalign (w_misalign)
  );

  // Counter holds the number of REQ cycles already spent; this is the last one.
  assign w_timeout = TO_EN && (r_tcnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= LSU_IDLE;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_wd    <= 32'd0;
      r_err   <= 1'b0;
      r_tcnt  <= 32'd0;
      r_rd    <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        LSU_IDLE: begin
          r_tcnt <= 32'd0;
          if (core_req_i) begin
            r_we   <= core_we_i;
            r_size <= core_size_i;
            r_addr <= core_addr_i;
            r_wd   <= core_wd_i;
            r_err  <= w_misalign;
          end
        end
        LSU_REQ: begin
          r_tcnt <= r_tcnt + 32'd1;
          if (mem_ready_i) begin
            if (!r_we) r_rd <= w_rd;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        core_stall_o = core_req_i;
        if (core_req_i) w_next = w_misalign ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        if (mem_ready_i || w_timeout) w_next = LSU_DONE;
      end
      LSU_DONE: w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  assign mem_we_o   = mem_req_o & r_we;
  assign mem_be_o   = mem_req_o ? w_be : 4'b0000;
  assign mem_addr_o = mem_req_o ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wd_o   = mem_req_o ? w_wd : 32'd0;
  assign lsu_err_o  = (r_state == LSU_DONE) & r_err;
  assign core_rd_o  = r_rd;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i   = wd;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; core_req_i = 0; core_we_i = 0; core_size_i = 0;
    core_addr_i = 0; core_wd_i = 0; mem_rd_i = 0; mem_ready_i = 0;
    tick(); tick();
    rst_i = 1'b0; #1;
    n_cmp++;
    if ({core_rd_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, lsu_err_o, core_stall_o} !== '0) begin
      n_bad++; $display("FAIL reset: rd=%h req=%b be=%b addr=%h wd=%h err=%b stall=%b want all 0",
        core_rd_o, mem_req_o, mem_be_o, mem_addr_o, mem_wd_o, lsu_err_o, core_stall_o);
    end
  endtask

  task automatic test_store_b();
    drive(1'b1, 3'd0, 32'h103, 32'hAABBCCDD); mem_ready_i = 1'b1; #1;
    n_cmp++;
    if ({core_stall_o, mem_req_o} !== 2'b10) begin
      n_bad++; $display("FAIL stb_idle: stall/req=%b want 10", {core_stall_o, mem_req_o});
    end
    tick();
    n_cmp++;
    if ({core_stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !==
        {3'b111, 4'b1000, 32'h100, 32'hDDDDDDDD}) begin
      n_bad++; $display("FAIL stb_req: stall=%b req=%b we=%b be=%b addr=%h wd=%h want 1 1 1 1000 100 dddddddd",
        core_stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o);
    end
    tick();
    core_req_i = 1'b0; #1;
    n_cmp++;
    if ({core_stall_o, mem_req_o, lsu_err_o, core_rd_o} !== {3'b000, 32'h0}) begin
      n_bad++; $display("FAIL stb_done: stall=%b req=%b err=%b rd=%h want 0 0 0 0",
        core_stall_o, mem_req_o, lsu_err_o, core_rd_o);
    end
    tick();
  endtask

  task automatic test_store_h();
    drive(1'b1, 3'd1, 32'h206, 32'h11225566); mem_ready_i = 1'b1;
    tick();
    n_cmp++;
    if ({mem_be_o, mem_addr_o, mem_wd_o} !== {4'b1100, 32'h204, 32'h55665566}) begin
      n_bad++; $display("FAIL sth_req: be=%b addr=%h wd=%h want 1100 204 55665566",
        mem_be_o, mem_addr_o, mem_wd_o);
    end
    tick(); core_req_i = 1'b0; tick();
  endtask

  task automatic test_load_h(input logic [2:0] sz, input logic [31:0] exp, input string nm);
    drive(1'b0, sz, 32'h202, 32'h0); mem_rd_i = 32'h80011234; mem_ready_i = 1'b1;
    tick();
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {2'b10, 4'b1100, 32'h200}) begin
      n_bad++; $display("FAIL %s_req: req=%b we=%b be=%b addr=%h want 1 0 1100 200",
        nm, mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    tick(); core_req_i = 1'b0; #1;
    n_cmp++;
    if (core_rd_o !== exp) begin
      n_bad++; $display("FAIL %s_data: rd=%h want %h", nm, core_rd_o, exp);
    end
    tick();
  endtask

  task automatic test_misalign(input logic [2:0] sz, input logic [31:0] a, input string nm);
    logic [31:0] hold;
    hold = core_rd_o;
    drive(1'b0, sz, a, 32'h0); mem_ready_i = 1'b1; mem_rd_i = 32'h12345678; #1;
    n_cmp++;
    if ({core_stall_o, mem_req_o, lsu_err_o} !== 3'b100) begin
      n_bad++; $display("FAIL %s_c1: stall=%b req=%b err=%b want 1 0 0", nm, core_stall_o, mem_req_o, lsu_err_o);
    end
    tick(); core_req_i = 1'b0; #1;
    n_cmp++;
    if ({core_stall_o, mem_req_o, lsu_err_o, core_rd_o} !== {3'b001, hold}) begin
      n_bad++; $display("FAIL %s_c2: stall=%b req=%b err=%b rd=%h want 0 0 1 %h",
        nm, core_stall_o, mem_req_o, lsu_err_o, core_rd_o, hold);
    end
    tick();
    n_cmp++;
    if (lsu_err_o !== 1'b0) begin
      n_bad++; $display("FAIL %s_pulse: err=%b want 0", nm, lsu_err_o);
    end
  endtask

  task automatic test_wait_states();
    int stalls = 0;
    drive(1'b0, 3'd2, 32'h400, 32'h0); mem_ready_i = 1'b0; mem_rd_i = 32'h0; #1;
    if (core_stall_o) stalls++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (core_stall_o) stalls++;
    end
    tick();
    mem_ready_i = 1'b1; mem_rd_i = 32'hCAFEBABE; #1;
    if (core_stall_o) stalls++;
    tick(); core_req_i = 1'b0; mem_ready_i = 1'b0; #1;
    if (core_stall_o) stalls++;
    n_cmp++;
    if (stalls !== 5) begin
      n_bad++; $display("FAIL wait_stalls: got %0d want 5", stalls);
    end
    n_cmp++;
    if ({core_rd_o, lsu_err_o} !== {32'hCAFEBABE, 1'b0}) begin
      n_bad++; $display("FAIL wait_data: rd=%h err=%b want cafebabe 0", core_rd_o, lsu_err_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    int reqs = 0;
    drive(1'b0, 3'd2, 32'h600, 32'h0); mem_ready_i = 1'b0; mem_rd_i = 32'h55555555;
    for (int i = 0; i < 10 && !lsu_err_o; i++) begin
      tick();
      if (mem_req_o) reqs++;
    end
    core_req_i = 1'b0; #1;
    n_cmp++;
    if (reqs !== 4) begin
      n_bad++; $display("FAIL to_cycles: got %0d want 4", reqs);
    end
    n_cmp++;
    if ({lsu_err_o, mem_req_o, core_stall_o, core_rd_o} !== {3'b100, 32'hCAFEBABE}) begin
      n_bad++; $display("FAIL to_done: err=%b req=%b stall=%b rd=%h want 1 0 0 cafebabe",
        lsu_err_o, mem_req_o, core_stall_o, core_rd_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_req();
    drive(1'b0, 3'd2, 32'h700, 32'h0); mem_ready_i = 1'b0;
    tick(); tick();
    n_cmp++;
    if (mem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre: req=%b want 1", mem_req_o);
    end
    rst_i = 1'b1; core_req_i = 1'b0;
    tick();
    n_cmp++;
    if ({mem_req_o, core_rd_o, core_stall_o, lsu_err_o} !== {1'b0, 32'h0, 2'b00}) begin
      n_bad++; $display("FAIL rst_mid: req=%b rd=%h stall=%b err=%b want 0 0 0 0",
        mem_req_o, core_rd_o, core_stall_o, lsu_err_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Load B at offset 1: byte 0x80 sign-extends.
    drive(1'b0, 3'd0, 32'h501, 32'h0); mem_ready_i = 1'b1; mem_rd_i = 32'h00008000;
    tick(); tick();
    // DONE cycle: next instruction presented immediately.
    drive(1'b1, 3'd2, 32'h504, 32'h0BADF00D); #1;
    n_cmp++;
    if (core_rd_o !== 32'hFFFFFF80) begin
      n_bad++; $display("FAIL b2b_ldb: rd=%h want ffffff80", core_rd_o);
    end
    tick();
    n_cmp++;
    if ({core_stall_o, mem_req_o} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_idle: stall/req=%b want 10", {core_stall_o, mem_req_o});
    end
    tick();
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !== {2'b11, 4'b1111, 32'h504, 32'h0BADF00D}) begin
      n_bad++; $display("FAIL b2b_stw: req=%b we=%b be=%b addr=%h wd=%h want 1 1 1111 504 0badf00d",
        mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o);
    end
    tick();
    // BU load right after the store.
    drive(1'b0, 3'd4, 32'h50B, 32'h0); mem_rd_i = 32'h9A000000; #1;
    n_cmp++;
    if ({core_rd_o, core_stall_o} !== {32'hFFFFFF80, 1'b0}) begin
      n_bad++; $display("FAIL b2b_hold: rd=%h stall=%b want ffffff80 0", core_rd_o, core_stall_o);
    end
    tick(); tick(); tick();
    core_req_i = 1'b0; #1;
    n_cmp++;
    if (core_rd_o !== 32'h0000009A) begin
      n_bad++; $display("FAIL b2b_ldbu: rd=%h want 0000009a", core_rd_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_b();
    test_store_h();
    test_load_h(3'd1, 32'hFFFF8001, "ldh");
    test_load_h(3'd5, 32'h00008001, "ldhu");
    test_misalign(3'd2, 32'h301, "misw");
    test_misalign(3'd5, 32'h303, "mishu");
    test_misalign(3'd3, 32'h300, "ill3");
    test_wait_states();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
